// File: rtl/dag_pkg.sv
// Shared constants, ureg group encoding and address-field helpers for the DAG.
package dag_pkg;

  localparam int unsigned DW   = 16;
  localparam int unsigned NREG = 8;
  localparam int unsigned IW   = 3;

  // 5-bit ureg address layout: [4:3] group, [2:0] register index
  localparam int unsigned UREG_GRP_MSB = 4;
  localparam int unsigned UREG_GRP_LSB = 3;
  localparam int unsigned UREG_IDX_MSB = 2;
  localparam int unsigned UREG_IDX_LSB = 0;

  typedef enum logic [1:0] {
    DG_GRP_I = 2'b00,
    DG_GRP_M = 2'b01,
    DG_GRP_L = 2'b10,
    DG_GRP_B = 2'b11
  } dg_grp_e;

  function automatic dg_grp_e ureg_grp(input logic [4:0] a);
    return dg_grp_e'(a[UREG_GRP_MSB:UREG_GRP_LSB]);
  endfunction

  function automatic logic [IW-1:0] ureg_idx(input logic [4:0] a);
    return a[UREG_IDX_MSB:UREG_IDX_LSB];
  endfunction

endpackage

// File: rtl/dag_circ_upd.sv
// Circular-buffer index update: I + signed modifier, folded once into [B, B+L).
module dag_circ_upd
  import dag_pkg::*;
#(
  parameter int unsigned W = DW
) (
  input  logic [W-1:0] i_val,
  input  logic [W-1:0] mod,
  input  logic [W-1:0] base,
  input  logic [W-1:0] len,
  output logic [W-1:0] wrapped
);

  logic [W:0] sum;
  logic [W:0] bound;
  logic       mod_neg;

  // Sign-extending the modifier into bit W makes sum[W] the borrow of I+mod
  // when mod is negative, so "below base" also catches an underflow of I+mod.
  always_comb begin
    mod_neg = mod[W-1];
    sum     = {1'b0, i_val} + {mod[W-1], mod};
    bound   = {1'b0, base} + {1'b0, len};
    wrapped = sum[W-1:0];
    if (len != '0) begin
      if (!mod_neg && (sum >= bound)) begin
        wrapped = sum[W-1:0] - len;
      end else if (mod_neg && (sum[W] || (sum[W-1:0] < base))) begin
        wrapped = sum[W-1:0] + len;
      end
    end
  end

endmodule

// File: rtl/dag_addr_gen.sv
// Data address generator: I/M/L/B register file, pre/post-modify addressing
// with circular wrap, ureg read/write port and registered address outputs.
module dag_addr_gen
  import dag_pkg::*;
#(
  parameter int unsigned NREG = dag_pkg::NREG,
  parameter int unsigned DW   = dag_pkg::DW
) (
  input  logic          clk_exe,
  input  logic          rst,
  input  logic          ps_dg_en,
  input  logic          ps_dg_dgsclt,
  input  logic          ps_dg_mdfy,
  input  logic [2:0]    ps_dg_iadd,
  input  logic [2:0]    ps_dg_madd,
  input  logic [DW-1:0] ps_dg_immdt,
  input  logic          ps_dg_wrt_en,
  input  logic [4:0]    ps_dg_wrt_add,
  input  logic [4:0]    ps_dg_rd_add,
  input  logic [DW-1:0] bc_dt,
  output logic [DW-1:0] dg_ps_add,
  output logic [DW-1:0] dg_dm_add,
  output logic          dg_dm_vld,
  output logic [DW-1:0] dg_bc_dt
);

  logic [DW-1:0] i_q [NREG];
  logic [DW-1:0] i_d [NREG];
  logic [DW-1:0] m_q [NREG];
  logic [DW-1:0] m_d [NREG];
  logic [DW-1:0] l_q [NREG];
  logic [DW-1:0] l_d [NREG];
  logic [DW-1:0] b_q [NREG];
  logic [DW-1:0] b_d [NREG];

  logic [DW-1:0] add_q, add_d;
  logic          vld_q, vld_d;

  logic [DW-1:0] i_sel;
  logic [DW-1:0] mod_sel;
  logic [DW-1:0] wrapped;
  dg_grp_e       wr_grp;
  dg_grp_e       rd_grp;
  logic [2:0]    wr_idx;
  logic [2:0]    rd_idx;

  // Operand selection for the address computation (pre-edge register values)
  always_comb begin
    i_sel   = i_q[ps_dg_iadd];
    mod_sel = ps_dg_mdfy ? ps_dg_immdt : m_q[ps_dg_madd];
    wr_grp  = ureg_grp(ps_dg_wrt_add);
    wr_idx  = ureg_idx(ps_dg_wrt_add);
    rd_grp  = ureg_grp(ps_dg_rd_add);
    rd_idx  = ureg_idx(ps_dg_rd_add);
  end

  dag_circ_upd #(.W(DW)) u_circ_upd (
    .i_val   (i_sel),
    .mod     (mod_sel),
    .base    (b_q[ps_dg_iadd]),
    .len     (l_q[ps_dg_iadd]),
    .wrapped (wrapped)
  );

  // Register-file next state; the ureg write is applied last so it overrides
  // a post-modify update of the same I register.
  always_comb begin
    i_d = i_q;
    m_d = m_q;
    l_d = l_q;
    b_d = b_q;
    if (ps_dg_en && !ps_dg_dgsclt) begin
      i_d[ps_dg_iadd] = wrapped;
    end
    if (ps_dg_wrt_en) begin
      case (wr_grp)
        DG_GRP_I: i_d[wr_idx] = bc_dt;
        DG_GRP_M: m_d[wr_idx] = bc_dt;
        DG_GRP_L: l_d[wr_idx] = bc_dt;
        DG_GRP_B: begin
          b_d[wr_idx] = bc_dt;
          i_d[wr_idx] = bc_dt;
        end
      endcase
    end
  end

  // Address output next state: hold address when idle, valid only on request
  always_comb begin
    add_d = add_q;
    vld_d = 1'b0;
    if (ps_dg_en) begin
      add_d = ps_dg_dgsclt ? wrapped : i_sel;
      vld_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk_exe) begin
    if (!rst) begin
      i_q   <= '{default: '0};
      m_q   <= '{default: '0};
      l_q   <= '{default: '0};
      b_q   <= '{default: '0};
      add_q <= '0;
      vld_q <= 1'b0;
    end else begin
      i_q   <= i_d;
      m_q   <= m_d;
      l_q   <= l_d;
      b_q   <= b_d;
      add_q <= add_d;
      vld_q <= vld_d;
    end
  end

  // Combinational ureg read, pre-edge value
  always_comb begin
    dg_bc_dt = '0;
    case (rd_grp)
      DG_GRP_I: dg_bc_dt = i_q[rd_idx];
      DG_GRP_M: dg_bc_dt = m_q[rd_idx];
      DG_GRP_L: dg_bc_dt = l_q[rd_idx];
      DG_GRP_B: dg_bc_dt = b_q[rd_idx];
    endcase
  end

  assign dg_ps_add = add_q;
  assign dg_dm_add = add_q;
  assign dg_dm_vld = vld_q;

endmodule

// File: doc/dag_addr_gen.md
Name: dag_addr_gen

Overview:
- Data address generator: the responder on the sequencer's `ps_dg_*` interface.
- Holds eight I/M/L/B register sets and computes DM addresses with pre- or post-modify and circular-buffer wrap.
- Returns the generated address to DM and to the sequencer on `dg_ps_add`, which serves as the jump/call target.
- Sits in the execute stage, between the sequencer, bus connect and data memory.

Parameters:
- NREG, 8, number of I/M/L/B register sets; index width is 3.
- DW, 16, register, address and data width.

Ports:
- clk_exe  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-low reset.
- ps_dg_en  input  1  address-generation request, one cycle wide.
- ps_dg_dgsclt  input  1  1 = pre-modify (address I+M, I unchanged); 0 = post-modify (address I, I updated).
- ps_dg_mdfy  input  1  modifier source: 1 = ps_dg_immdt, 0 = M[ps_dg_madd].
- ps_dg_iadd  input  3  I/L/B set index.
- ps_dg_madd  input  3  M register index.
- ps_dg_immdt  input  DW  immediate modifier, two's complement.
- ps_dg_wrt_en  input  1  ureg write strobe.
- ps_dg_wrt_add  input  5  ureg write address: [4:3] group (00 I, 01 M, 10 L, 11 B), [2:0] index.
- ps_dg_rd_add  input  5  ureg read address, same encoding.
- bc_dt  input  DW  write data from bus connect.
- dg_ps_add  output  DW  generated address, registered.
- dg_dm_add  output  DW  DM address, registered; equal to dg_ps_add.
- dg_dm_vld  output  1  dg_dm_add is valid this cycle.
- dg_bc_dt  output  DW  ureg read data, combinational.

Behaviour:
- Reset (rst=0 at posedge): all I/M/L/B registers = 0; dg_ps_add = 0, dg_dm_add = 0, dg_dm_vld = 0. Reset mid-operation discards any pending request; the output is 0 on the following cycle.
- Latency: a request sampled at edge N produces dg_ps_add/dg_dm_add with dg_dm_vld=1 after edge N. With ps_dg_en=0, dg_dm_vld falls to 0 and the address outputs hold their last value.
- Modifier: mod = ps_dg_mdfy ? ps_dg_immdt : M[madd]. Always treated as signed 16-bit.
- Raw sum: sum = I + mod, computed at 17 bits, unsigned address domain.
- Wrap, when L[iadd] != 0:
  - mod >= 0 and sum >= B+L (17-bit compare): wrapped = sum - L.
  - mod < 0 and sum < B (17-bit compare, using the borrow of I+mod): wrapped = sum + L.
  - Otherwise wrapped = sum[15:0].
  - Correctness requires |mod| < L; larger modifiers give the result of a single correction only.
- No wrap, when L[iadd] == 0: wrapped = sum[15:0], modulo 2^16.
- Pre-modify: address = wrapped; I is not written.
- Post-modify: address = I (old value); I[iadd] <= wrapped at the same edge.
- Ureg write (ps_dg_wrt_en=1) writes the addressed register with bc_dt.
  - A write to B[k] also loads I[k] <= bc_dt.
  - A write to L[k] does not touch I or B.
- Simultaneous events:
  - Ureg write to I[k] (direct, or via B[k]) in the same cycle as a post-modify of I[k]: the ureg write wins.
  - Address computation uses register values before the edge; a same-cycle write is not bypassed into the address.
- Read: dg_bc_dt = register at ps_dg_rd_add, combinational, pre-edge value; a same-cycle write is not bypassed. Unused encodings cannot occur with 5-bit addressing.
- ps_dg_en and ps_dg_wrt_en may be asserted together; both take effect.

Decomposition:
- Package dag_pkg:
  - DW, NREG.
  - Group codes DG_GRP_I=2'b00, DG_GRP_M=2'b01, DG_GRP_L=2'b10, DG_GRP_B=2'b11.
  - Field slices for the 5-bit ureg address.
- One sub-module, dag_circ_upd: combinational (I, mod, B, L) -> wrapped. It contains the 17-bit sum, the sign-based compare and the single L correction, and is reused for both pre- and post-modify paths.
- The top level holds the register arrays, ureg read/write decode and the output registers.

Test Plan:
- Post-modify, no wrap:
  - Stimulus: write I0=0x0100, M1=0x0004, L0=0; request iadd=0, madd=1, mdfy=0, dgsclt=0.
  - Response: dg_dm_add=0x0100, dg_dm_vld=1 next cycle; I0 reads 0x0104.
- Pre-modify with immediate:
  - Stimulus: I2=0x2000, immdt=0xFFFE (-2), mdfy=1, dgsclt=1.
  - Response: dg_ps_add=0x1FFE; I2 still 0x2000.
- Circular forward and backward wrap:
  - Setup: B3=0x0040 (I3 becomes 0x0040), L3=8.
  - Five post-modifies with immdt=3 give addresses 0x40, 0x43, 0x46, 0x41, 0x44.
  - Then with immdt=-3 (0xFFFD) from I3=0x41: address 0x41, I3 becomes 0x46.
- Collision:
  - Stimulus: same cycle, post-modify of I4 and ureg write I4=0x5555.
  - Response: I4=0x5555 after the edge; that cycle's address is the old I4.
- Reset mid-stream:
  - Stimulus: rst=0 for one edge while ps_dg_en=1.
  - Response: dg_dm_vld=0, dg_ps_add=0, all registers read 0.
- 16-bit overflow with L=0:
  - Stimulus: I5=0xFFFF, immdt=2, post-modify.
  - Response: address 0xFFFF; I5 becomes 0x0001.
